// File: rtl/sap_flags_unit.sv
// sap_flags_unit: masked-op flags register with a save/restore stack and sticky overflow/underflow flags
module sap_flags_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] IN,
    input  logic [WIDTH-1:0] mask,
    input  logic [1:0]       op,
    input  logic             latch,
    input  logic             push,
    input  logic             pop,
    input  logic             err_clear,
    output logic [WIDTH-1:0] OUT,
    output logic [CW-1:0]    count,
    output logic             empty,
    output logic             full,
    output logic             ovf,
    output logic             unf
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    logic [WIDTH-1:0] stack [DEPTH];
    logic [WIDTH-1:0] opr, nxt;
    logic [IW-1:0]    top, wr;
    logic             pop_ok, push_ok;
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign top     = IW'(count - CW'(1));
    assign wr      = IW'(count);
    assign pop_ok  = pop && !empty;
    // push paired with a failed pop still saves as a plain push
    assign push_ok = push && !pop_ok && !full;
    always_comb begin
        opr = op == 2'd0 ? IN : op == 2'd1 ? OUT | IN : op == 2'd2 ? OUT & ~IN : OUT ^ IN;
        nxt = latch ? (mask & opr) | (~mask & OUT) : OUT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            OUT   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            OUT <= pop_ok ? stack[top] : nxt;
            if (push_ok)
                count <= count + CW'(1);
            else if (pop_ok && !push)
                count <= count - CW'(1);
            ovf <= (ovf & ~err_clear) | (push & ~pop & full);
            unf <= (unf & ~err_clear) | (pop & ~push & empty);
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (pop_ok && push)
                stack[top] <= OUT;
            else if (push_ok)
                stack[wr] <= OUT;
        end
    end
endmodule

// File: tb/tb_sap_flags_unit.sv
// tb_sap_flags_unit: directed vectors checked every cycle against a queue-based flags model
module tb_sap_flags_unit;
    logic       clk = 0, reset = 0, latch = 0, push = 0, pop = 0, err_clear = 0;
    logic [7:0] IN = 0, mask = 0, OUT;
    logic [1:0] op = 0;
    logic [2:0] count;
    logic       empty, full, ovf, unf;
    int         tests = 0, fails = 0;
    logic       en = 0;
    logic [7:0] mr = 0;
    logic [7:0] mq [$];
    logic       movf = 0, munf = 0;

    sap_flags_unit dut (.clk(clk), .reset(reset), .IN(IN), .mask(mask), .op(op), .latch(latch),
        .push(push), .pop(pop), .err_clear(err_clear), .OUT(OUT), .count(count),
        .empty(empty), .full(full), .ovf(ovf), .unf(unf));

    always #5 clk = ~clk;

    always @(negedge clk) begin
        logic [14:0] act, exp;
        if (en) begin
            act = {OUT, count, empty, full, ovf, unf};
            exp = {mr, 3'(mq.size()), mq.size() == 0, mq.size() == 4, movf, munf};
            tests++;
            if (act !== exp) begin
                fails++;
                $display("FAIL cycle t=%0t {OUT,count,empty,full,ovf,unf} got %h want %h", $time, act, exp);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s got %h want %h", name, a, e);
        end
    endtask

    task automatic cyc(input logic rs, input logic la, input logic [1:0] o, input logic [7:0] m,
                       input logic [7:0] i, input logic pu, input logic po, input logic ec);
        logic [7:0] nr, t;
        logic [7:0] nq [$];
        logic       no, nu;
        reset = rs; latch = la; op = o; mask = m; IN = i; push = pu; pop = po; err_clear = ec;
        nq = mq; nr = mr;
        no = (movf && !ec) || (pu && !po && mq.size() == 4);
        nu = (munf && !ec) || (po && !pu && mq.size() == 0);
        if (rs) begin
            nq.delete(); nr = 0; no = 0; nu = 0;
        end else if (po && mq.size() > 0) begin
            t = nq[$];
            if (pu) nq[nq.size()-1] = mr;
            else void'(nq.pop_back());
            nr = t;
        end else begin
            if (la)
                for (int b = 0; b < 8; b++)
                    if (m[b])
                        case (o)
                            2'd0: nr[b] = i[b];
                            2'd1: nr[b] = mr[b] | i[b];
                            2'd2: nr[b] = mr[b] & ~i[b];
                            default: nr[b] = mr[b] ^ i[b];
                        endcase
            if (pu && mq.size() < 4) nq.push_back(mr);
        end
        @(posedge clk);
        mq = nq; mr = nr; movf = no; munf = nu;
        #1;
        reset = 0; latch = 0; push = 0; pop = 0; err_clear = 0;
    endtask

    task automatic ld(input logic [7:0] v);
        cyc(0, 1, 2'd0, 8'hFF, v, 0, 0, 0);
    endtask

    initial begin
        @(negedge clk);
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        en = 1;
        chk("reset", {OUT, count, empty, full, ovf, unf}, {8'h00, 3'd0, 4'b1000});
        ld(8'hA5);
        chk("load_a5", OUT, 8'hA5);
        cyc(0, 1, 2'd1, 8'h0F, 8'hF0, 0, 0, 0);
        chk("set_masked", OUT, 8'hA5);
        cyc(0, 1, 2'd3, 8'hFF, 8'hFF, 0, 0, 0);
        chk("toggle", OUT, 8'h5A);
        ld(8'hFF);
        cyc(0, 1, 2'd2, 8'hC0, 8'hFF, 0, 0, 0);
        chk("clear_c0", OUT, 8'h3F);
        cyc(0, 1, 2'd1, 8'h81, 8'hFF, 0, 0, 0);
        chk("set_81", OUT, 8'hBF);
        for (int k = 1; k <= 4; k++) begin
            ld(8'(k * 8'h11));
            cyc(0, 0, 0, 0, 0, 1, 0, 0);
        end
        chk("full4", {count, full, empty}, {3'd4, 2'b10});
        cyc(0, 0, 0, 0, 0, 1, 0, 0);
        chk("ovf", {count, ovf}, {3'd4, 1'b1});
        for (int k = 4; k >= 1; k--) begin
            cyc(0, 0, 0, 0, 0, 0, 1, 0);
            chk("pop_order", OUT, 8'(k * 8'h11));
        end
        chk("drained", {count, empty}, {3'd0, 1'b1});
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_clr", ovf, 1'b0);
        cyc(0, 1, 2'd0, 8'hFF, 8'h77, 0, 1, 0);
        chk("unf_latch", {OUT, unf}, {8'h77, 1'b1});
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        chk("unf_clr", unf, 1'b0);
        cyc(0, 0, 0, 0, 0, 0, 1, 1);
        chk("unf_wins", unf, 1'b1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        ld(8'h12);
        cyc(0, 1, 2'd0, 8'hFF, 8'h34, 1, 0, 0);
        chk("push_latch", {OUT, count}, {8'h34, 3'd1});
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        chk("exchange", {OUT, count}, {8'h12, 3'd1});
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("exch_top", {OUT, count}, {8'h34, 3'd0});
        cyc(0, 0, 0, 0, 0, 1, 1, 0);
        chk("pushpop_empty", {count, unf}, {3'd1, 1'b0});
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("pushpop_empty_pop", OUT, 8'h34);
        for (int k = 0; k < 5; k++) cyc(0, 0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("pre_reset", {count, ovf}, {3'd3, 1'b1});
        cyc(1, 1, 2'd0, 8'hFF, 8'hEE, 1, 0, 0);
        chk("mid_reset", {OUT, count, empty, ovf}, {8'h00, 3'd0, 1'b1, 1'b0});
        cyc(0, 0, 0, 0, 0, 0, 1, 0);
        chk("post_reset_unf", unf, 1'b1);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
